// File: rtl/irq_vector_dispatch.sv
// Registered dispatch stage after the priority interrupt encoder: glitch-filters
// the grant flags, offers a 6-bit vector over valid/ready and tracks one in-service IRQ.
module irq_vector_dispatch #(
    parameter int STABLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pa,
    input  logic       pb,
    input  logic       pc,
    input  logic [3:0] chan,
    input  logic       irq_ready,
    input  logic       eoi,
    output logic       irq_valid,
    output logic [5:0] irq_vec,
    output logic       in_service,
    output logic [2:0] mask_bus,
    output logic [7:0] spurious_cnt,
    output logic [7:0] drop_cnt,
    output logic [1:0] fsm_state
);

    // Handshake: the vector transfers on any rising edge where irq_valid and
    // irq_ready are both high; irq_vec is stable while irq_valid is high.

    typedef enum logic [1:0] {IDLE, QUAL, PRESENT, SERVICE} state_t;

    localparam logic [4:0] STABLE  = 5'(STABLE_CYCLES);
    localparam logic [8:0] TIMEOUT = 9'(ACK_TIMEOUT);

    state_t     state;
    logic [5:0] cand;
    logic [3:0] cnt;
    logic [7:0] tcnt;
    logic       any;
    logic [1:0] bus;
    logic [5:0] cur;

    assign any       = pa | pb | pc;
    assign bus       = pa ? 2'd0 : (pb ? 2'd1 : 2'd2);
    assign cur       = {bus, chan};
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            irq_valid    <= 1'b0;
            irq_vec      <= '0;
            in_service   <= 1'b0;
            mask_bus     <= '0;
            spurious_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        cand <= cur;
                        if (STABLE_CYCLES == 1) begin
                            state     <= PRESENT;
                            tcnt      <= '0;
                            irq_valid <= 1'b1;
                            irq_vec   <= cur;
                        end else begin
                            cnt   <= 4'd1;
                            state <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (!any) begin
                        state <= IDLE;
                        if (spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
                    end else if (cur != cand) begin
                        cand <= cur;
                        cnt  <= 4'd1;
                    end else if ({1'b0, cnt} + 5'd1 == STABLE) begin
                        state     <= PRESENT;
                        tcnt      <= '0;
                        irq_valid <= 1'b1;
                        irq_vec   <= cand;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                PRESENT: begin
                    // Ready wins over a timeout landing on the same edge.
                    if (irq_ready) begin
                        state      <= SERVICE;
                        irq_valid  <= 1'b0;
                        irq_vec    <= '0;
                        in_service <= 1'b1;
                        mask_bus   <= 3'(3'b001 << cand[5:4]);
                    end else if (ACK_TIMEOUT != 0 && {1'b0, tcnt} + 9'd1 == TIMEOUT) begin
                        state     <= IDLE;
                        irq_valid <= 1'b0;
                        irq_vec   <= '0;
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                        mask_bus   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_dispatch.sv
// Directed bench for irq_vector_dispatch: three instances (default, short
// timeout, single-cycle qualification) share the stimulus.
module tb_irq_vector_dispatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pa = 1'b0, pb = 1'b0, pc = 1'b0;
    logic [3:0] chan = '0;
    logic       irq_ready = 1'b0;
    logic       eoi = 1'b0;

    logic       d_valid, t_valid, s_valid;
    logic [5:0] d_vec, t_vec, s_vec;
    logic       d_insvc, t_insvc, s_insvc;
    logic [2:0] d_mask, t_mask, s_mask;
    logic [7:0] d_spur, t_spur, s_spur;
    logic [7:0] d_drop, t_drop, s_drop;
    logic [1:0] d_state, t_state, s_state;

    int n_vec = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    irq_vector_dispatch #(.STABLE_CYCLES(2), .ACK_TIMEOUT(64)) u_def (
        .clk(clk), .rst_n(rst_n), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
        .irq_ready(irq_ready), .eoi(eoi), .irq_valid(d_valid), .irq_vec(d_vec),
        .in_service(d_insvc), .mask_bus(d_mask), .spurious_cnt(d_spur),
        .drop_cnt(d_drop), .fsm_state(d_state));

    irq_vector_dispatch #(.STABLE_CYCLES(2), .ACK_TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
        .irq_ready(irq_ready), .eoi(eoi), .irq_valid(t_valid), .irq_vec(t_vec),
        .in_service(t_insvc), .mask_bus(t_mask), .spurious_cnt(t_spur),
        .drop_cnt(t_drop), .fsm_state(t_state));

    irq_vector_dispatch #(.STABLE_CYCLES(1), .ACK_TIMEOUT(64)) u_s1 (
        .clk(clk), .rst_n(rst_n), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
        .irq_ready(irq_ready), .eoi(eoi), .irq_valid(s_valid), .irq_vec(s_vec),
        .in_service(s_insvc), .mask_bus(s_mask), .spurious_cnt(s_spur),
        .drop_cnt(s_drop), .fsm_state(s_state));

    // driver tasks: advance one edge, then settle 1 time unit before sampling/driving
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input logic a, input logic b, input logic c, input logic [3:0] ch);
        pa = a; pb = b; pc = c; chan = ch;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_def_quiet(input string tag);
        check({tag, ".valid"}, 32'(d_valid), 32'd0);
        check({tag, ".vec"},   32'(d_vec),   32'd0);
        check({tag, ".insvc"}, 32'(d_insvc), 32'd0);
        check({tag, ".mask"},  32'(d_mask),  32'd0);
        check({tag, ".state"}, 32'(d_state), 32'd0);
    endtask

    initial begin
        // reset state
        set_req(1'b0, 1'b0, 1'b0, 4'd0);
        step(2);
        check_def_quiet("rst");
        check("rst.spur", 32'(d_spur), 32'd0);
        check("rst.drop", 32'(d_drop), 32'd0);
        rst_n = 1'b1;

        // basic flow: pa, chan=5
        set_req(1'b1, 1'b0, 1'b0, 4'd5);
        exp_q.push_back(6'b00_0101);
        step(1);
        check("basic.e1.valid", 32'(d_valid), 32'd0);
        step(1);
        check("basic.e2.valid", 32'(d_valid), 32'd1);
        check("basic.e2.vec", 32'(d_vec), 32'(exp_q.pop_front()));
        step(1);
        irq_ready = 1'b1;
        step(1);
        irq_ready = 1'b0;
        check("basic.acc.insvc", 32'(d_insvc), 32'd1);
        check("basic.acc.mask", 32'(d_mask), 32'b001);
        check("basic.acc.valid", 32'(d_valid), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 4'd0);
        step(2);
        check("basic.e6.insvc", 32'(d_insvc), 32'd1);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_def_quiet("basic.eoi");

        // glitch: one-cycle pb
        set_req(1'b0, 1'b1, 1'b0, 4'd7);
        step(1);
        check("glitch.e1.valid", 32'(d_valid), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        check("glitch.e2.valid", 32'(d_valid), 32'd0);
        check("glitch.spur", 32'(d_spur), 32'd1);

        // pc with chan alternating 4/3, ending on 3
        for (int i = 0; i < 6; i++) begin
            set_req(1'b0, 1'b0, 1'b1, (i % 2) ? 4'd3 : 4'd4);
            step(1);
            check("alt.valid", 32'(d_valid), 32'd0);
        end
        chan = 4'd4;
        exp_q.push_back(6'b10_0100);
        step(1);
        check("alt.hold1.valid", 32'(d_valid), 32'd0);
        step(1);
        check("alt.hold2.valid", 32'(d_valid), 32'd1);
        check("alt.hold2.vec", 32'(d_vec), 32'(exp_q.pop_front()));
        check("alt.spur", 32'(d_spur), 32'd1);
        do_reset();

        // priority encode: pb and pc both set, pb wins
        set_req(1'b0, 1'b1, 1'b1, 4'd9);
        exp_q.push_back(6'b01_1001);
        step(2);
        check("prio.valid", 32'(d_valid), 32'd1);
        check("prio.vec", 32'(d_vec), 32'(exp_q.pop_front()));
        irq_ready = 1'b1;
        step(1);
        irq_ready = 1'b0;
        check("prio.mask", 32'(d_mask), 32'b010);
        check("prio.insvc", 32'(d_insvc), 32'd1);

        // in SERVICE: input changes and ready toggles are ignored
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 1'b0, 4'(i + 2));
            irq_ready = i[0];
            step(1);
            check("svc.mask", 32'(d_mask), 32'b010);
            check("svc.insvc", 32'(d_insvc), 32'd1);
            check("svc.valid", 32'(d_valid), 32'd0);
            check("svc.vec", 32'(d_vec), 32'd0);
        end
        irq_ready = 1'b0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_def_quiet("svc.rst");
        set_req(1'b0, 1'b0, 1'b0, 4'd0);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check_def_quiet("idle.eoi");

        // timeout (ACK_TIMEOUT=4), ready held low
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 4'd1);
        step(2);
        check("to.present", 32'(t_valid), 32'd1);
        step(3);
        check("to.e3.valid", 32'(t_valid), 32'd1);
        step(1);
        check("to.e4.valid", 32'(t_valid), 32'd0);
        check("to.e4.drop", 32'(t_drop), 32'd1);

        // ready coincident with the 4th PRESENT edge transfers
        step(2);
        check("to.co.present", 32'(t_valid), 32'd1);
        step(3);
        irq_ready = 1'b1;
        step(1);
        irq_ready = 1'b0;
        check("to.co.insvc", 32'(t_insvc), 32'd1);
        check("to.co.valid", 32'(t_valid), 32'd0);
        check("to.co.drop", 32'(t_drop), 32'd1);
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        check("to.co.eoi", 32'(t_insvc), 32'd0);

        // 300 more timeouts saturate drop_cnt
        for (int i = 0; i < 300; i++) begin
            step(6);
            if (i == 252) check("to.sat254", 32'(t_drop), 32'd254);
        end
        check("to.sat.drop", 32'(t_drop), 32'd255);
        check("to.sat.valid", 32'(t_valid), 32'd0);

        // STABLE_CYCLES=1
        set_req(1'b0, 1'b0, 1'b0, 4'd0);
        do_reset();
        set_req(1'b1, 1'b0, 1'b0, 4'd0);
        step(1);
        check("s1.valid", 32'(s_valid), 32'd1);
        check("s1.vec", 32'(s_vec), 32'd0);
        check("s1.def.valid", 32'(d_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irq_vector_dispatch.md
# irq_vector_dispatch

Registered dispatch stage directly downstream of the 27-channel priority interrupt encoder. It takes the encoder's combinational bus-grant flags and encoded channel number, glitch-filters them, and forms a 6-bit interrupt vector. It presents the vector to the CPU over a valid/ready handshake and tracks the single in-service interrupt until end-of-interrupt. While an interrupt is in service, it drives a per-bus mask back to the request-gating logic upstream of the encoder.

## Interface
Parameters:
- STABLE_CYCLES, 2: consecutive identical samples needed to qualify a request; legal range 1..15.
- ACK_TIMEOUT, 64: cycles in PRESENT without `irq_ready` before the vector is dropped; 0 disables the timeout; legal range 0..255.

Ports (reset is synchronous and active-low; one clock):
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- pa  in  1  bus A grant flag from the encoder; highest priority.
- pb  in  1  bus B grant flag.
- pc  in  1  bus C grant flag; lowest priority.
- chan  in  4  encoded channel number within the granted bus.
- irq_ready  in  1  CPU accepts the vector.
- eoi  in  1  single-cycle end-of-interrupt strobe from the CPU.
- irq_valid  out  1  vector offered.
- irq_vec  out  6  {bus[1:0], chan[3:0]}; bus = 0 if pa, else 1 if pb, else 2.
- in_service  out  1  a vector was accepted and no EOI has been seen yet.
- mask_bus  out  3  one-hot mask {C,B,A} of the in-service bus; 0 otherwise.
- spurious_cnt  out  8  saturating count of requests that vanished during qualification.
- drop_cnt  out  8  saturating count of ACK timeouts.

## Operation
- `any = pa|pb|pc`. `cur = {bus, chan}` is computed combinationally from the inputs every cycle.
- States: IDLE, QUAL, PRESENT, SERVICE. Internal registers: candidate `cand[5:0]`, stability counter `cnt[3:0]`, timeout counter `tcnt[7:0]`.
- IDLE, when `any`:
  - if STABLE_CYCLES == 1: `cand <= cur`, go to PRESENT.
  - otherwise: `cand <= cur`, `cnt <= 1`, go to QUAL.
- IDLE with `!any`: stay in IDLE.
- QUAL, evaluated in this priority order:
  - `!any`: go to IDLE and increment `spurious_cnt`, saturating at 255.
  - `cur != cand`: `cand <= cur`, `cnt <= 1`, stay in QUAL.
  - `cnt + 1 == STABLE_CYCLES`: go to PRESENT.
  - otherwise: `cnt <= cnt + 1`.
- PRESENT:
  - `irq_valid = 1` and `irq_vec = cand`. The vector is held constant and input changes are ignored.
  - `irq_valid & irq_ready` on an edge: transfer; go to SERVICE.
  - Otherwise `tcnt` increments. When ACK_TIMEOUT != 0 and `tcnt + 1 == ACK_TIMEOUT`, go to IDLE and increment `drop_cnt` (saturating).
  - A ready on the same edge as the timeout wins, so the transfer occurs.
  - `tcnt` clears on entry to PRESENT.
- SERVICE:
  - `in_service = 1` and `mask_bus = 1 << cand[5:4]`.
  - `eoi`: go to IDLE.
  - `irq_valid = 0`.
- `eoi` is ignored in IDLE, QUAL and PRESENT. `irq_ready` is ignored outside PRESENT.
- `irq_vec` reads 0 whenever `irq_valid = 0`.

## Timing
- Reset: all outputs are 0, state is IDLE, and all counters are 0. `rst_n` low on any edge aborts any state, including a pending or in-service vector, with no counter updates.
- Qualification latency: a request stable from before edge 1 gives `irq_valid` high after edge STABLE_CYCLES (after edge 2 by default).
- Each change of `cur` during QUAL restarts the count at 1.
- Transfer completes on the ready edge. `irq_valid` falls and `in_service` rises in the same cycle.
- EOI at edge k: `in_service` and `mask_bus` are 0 after edge k. A new request may enter QUAL at edge k+1 at the earliest.
- Timeout at the ACK_TIMEOUT-th PRESENT edge: `irq_valid` is 0 after that edge.
- Counters hold at 255 and never wrap.

## Test plan
- Reset, default params: hold pa=1, chan=5 from before edge 1. Require `irq_valid=1` and `irq_vec=6'b00_0101` after edge 2. Assert `irq_ready` at edge 4. Require `in_service=1`, `mask_bus=3'b001`, `irq_valid=0`. Pulse `eoi` at edge 7. Require all outputs 0 after edge 7.
- Glitch: pb=1 for one cycle, then all flags 0. Require `irq_valid` to stay 0 and `spurious_cnt=1`. Next, pc=1 with chan alternating 3/4 each cycle. Require no `irq_valid` while alternating. Then chan held at 4. Require `irq_vec=6'b10_0100` after 2 stable edges.
- Priority encode: pa=0, pb=1, pc=1, chan=9. Require `irq_vec=6'b01_1001` and, after accept, `mask_bus=3'b010`.
- Timeout with ACK_TIMEOUT=4 and `irq_ready` held 0: require `irq_valid` low after the 4th PRESENT edge and `drop_cnt=1`. Repeat 300 times and require `drop_cnt=255`. Ready coincident with the 4th edge gives a transfer with `drop_cnt` unchanged.
- In SERVICE, change pa/chan, toggle `irq_ready`, and deassert `rst_n` for one edge. Before the reset, require the vector and mask unchanged. After the reset edge, require all outputs 0 and state IDLE. An `eoi` pulse while in IDLE has no effect.
- STABLE_CYCLES=1: pa=1, chan=0 before edge 1. Require `irq_valid` after edge 1.
